// File: rtl/jogo_pkg.sv
// jogo_pkg: shared state codes, LFSR feedback mask and one-hot helper for the sequence game.
package jogo_pkg;
  typedef enum logic [3:0] {
    INICIAL     = 4'h0,
    PREPARA     = 4'h1,
    CARREGA     = 4'h2,
    MOSTRA      = 4'h3,
    APAGA       = 4'h4,
    ESPERA      = 4'h5,
    REGISTRA    = 4'h6,
    COMPARA     = 4'h7,
    PROX_JOGADA = 4'h8,
    PROX_RODADA = 4'h9,
    FIM_ACERTO  = 4'hA,
    FIM_TIMEOUT = 4'hD,
    FIM_ERRO    = 4'hE
  } estado_t;
  // Galois mask for x^16 + x^14 + x^13 + x^11 + 1, right-shifting form
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  function automatic logic [7:0] onehot(input logic [2:0] idx);
    return 8'(1) << idx;
  endfunction
endpackage

// File: rtl/jogo_lfsr.sv
// jogo_lfsr: free-running 16-bit Galois LFSR, loads SEMENTE on synchronous active-low reset.
module jogo_lfsr
  import jogo_pkg::*;
#(
  parameter logic [15:0] SEMENTE = 16'hACE1
) (
  input  logic        i_clock,
  input  logic        i_reset,
  output logic [15:0] o_lfsr
);
  logic [15:0] r_lfsr;
  always_ff @(posedge i_clock)
    if (!i_reset) r_lfsr <= SEMENTE;
    else r_lfsr <= (r_lfsr >> 1) ^ (r_lfsr[0] ? LFSR_TAPS : 16'h0);
  assign o_lfsr = r_lfsr;
endmodule

// File: rtl/jogo_sequencia_param.sv
// jogo_sequencia_param: parametrised sequence-memory game core (FSM, counters, sequence memory).
// Define JOGO_TIMEOUT_EN to build the per-move timer and the FIM_TIMEOUT outcome.
module jogo_sequencia_param
  import jogo_pkg::*;
#(
  parameter int          N_CHAVES       = 4,
  parameter int          PROFUNDIDADE   = 16,
  parameter int          TIMEOUT_CICLOS = 5000,
  parameter int          T_MOSTRA       = 1000,
  parameter int          T_APAGA        = 250,
  parameter logic [15:0] SEMENTE        = 16'hACE1
) (
  input  logic                            i_clock,
  input  logic                            i_reset,
  input  logic                            i_iniciar,
  input  logic [N_CHAVES-1:0]             i_chaves,
  input  logic                            i_nivel_jogadas,
  input  logic                            i_nivel_tempo,
  output logic                            o_acertou,
  output logic                            o_errou,
  output logic                            o_timeout,
  output logic                            o_pronto,
  output logic                            o_vez_jogador,
  output logic [N_CHAVES-1:0]             o_leds,
  output logic [3:0]                      o_db_estado,
  output logic [$clog2(PROFUNDIDADE)-1:0] o_db_rodada,
  output logic [$clog2(PROFUNDIDADE)-1:0] o_db_endereco,
  output logic [N_CHAVES-1:0]             o_db_memoria
);
  localparam int AW = $clog2(PROFUNDIDADE);
  localparam int TW = $clog2((T_MOSTRA > T_APAGA ? T_MOSTRA : T_APAGA) + 1);
  estado_t             r_estado;
  logic [AW-1:0]       r_rodada, r_addr, w_ultima;
  logic [TW-1:0]       r_tmr;
  logic [N_CHAVES-1:0] r_mem [PROFUNDIDADE];
  logic [N_CHAVES-1:0] r_jogada, r_chaves_prev;
  logic                r_nivel_jogadas;
  logic [15:0]         w_lfsr;
  logic [2:0]          w_idx;
  logic                w_jogada_feita, w_estouro;

  jogo_lfsr #(.SEMENTE(SEMENTE)) u_lfsr (
    .i_clock(i_clock),
    .i_reset(i_reset),
    .o_lfsr (w_lfsr)
  );

`ifdef JOGO_TIMEOUT_EN
  localparam int MW = $clog2(TIMEOUT_CICLOS + 1);
  logic [MW-1:0] r_tmr_mov;
  logic          r_nivel_tempo;
  always_ff @(posedge i_clock)
    if (!i_reset) begin
      r_tmr_mov     <= '0;
      r_nivel_tempo <= 1'b0;
    end else begin
      if (r_estado == PREPARA) r_nivel_tempo <= i_nivel_tempo;
      r_tmr_mov <= (r_estado == ESPERA && r_nivel_tempo) ? r_tmr_mov + 1'b1 : '0;
    end
  assign w_estouro = r_estado == ESPERA && r_nivel_tempo && r_tmr_mov == MW'(TIMEOUT_CICLOS - 1);
  assign o_timeout = r_estado == FIM_TIMEOUT;
`else
  logic w_unused;
  assign w_unused  = i_nivel_tempo ^ (TIMEOUT_CICLOS > 0);
  assign w_estouro = 1'b0;
  assign o_timeout = 1'b0;
`endif

  // A move is a rising edge of "any key": held keys must be released first.
  assign w_jogada_feita = |i_chaves && ~|r_chaves_prev;
  assign w_ultima       = r_nivel_jogadas ? AW'(PROFUNDIDADE - 1) : AW'(PROFUNDIDADE / 2 - 1);
  assign w_idx          = 3'(w_lfsr % 16'(N_CHAVES));

  always_ff @(posedge i_clock)
    if (r_estado == CARREGA) r_mem[r_addr] <= N_CHAVES'(onehot(w_idx));

  always_ff @(posedge i_clock)
    if (!i_reset) begin
      r_estado        <= INICIAL;
      r_rodada        <= '0;
      r_addr          <= '0;
      r_tmr           <= '0;
      r_jogada        <= '0;
      r_chaves_prev   <= '0;
      r_nivel_jogadas <= 1'b0;
    end else begin
      r_chaves_prev <= i_chaves;
      case (r_estado)
        INICIAL, FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT: if (i_iniciar) r_estado <= PREPARA;
        PREPARA: begin
          r_nivel_jogadas <= i_nivel_jogadas;
          r_rodada        <= '0;
          r_addr          <= '0;
          r_tmr           <= '0;
          r_estado        <= CARREGA;
        end
        CARREGA: if (r_addr == AW'(PROFUNDIDADE - 1)) begin
          r_addr   <= '0;
          r_jogada <= '0;
          r_estado <= MOSTRA;
        end else r_addr <= r_addr + 1'b1;
        MOSTRA: if (r_tmr == TW'(T_MOSTRA - 1)) begin
          r_tmr    <= '0;
          r_estado <= APAGA;
        end else r_tmr <= r_tmr + 1'b1;
        APAGA: if (r_tmr == TW'(T_APAGA - 1)) begin
          r_tmr    <= '0;
          r_addr   <= r_addr == r_rodada ? '0 : r_addr + 1'b1;
          r_estado <= r_addr == r_rodada ? ESPERA : MOSTRA;
        end else r_tmr <= r_tmr + 1'b1;
        // A press in the same cycle as the timer expiring takes priority.
        ESPERA: if (w_jogada_feita) begin
          r_jogada <= i_chaves;
          r_estado <= REGISTRA;
        end else if (w_estouro) r_estado <= FIM_TIMEOUT;
        REGISTRA: r_estado <= COMPARA;
        COMPARA: r_estado <= r_jogada != r_mem[r_addr] ? FIM_ERRO :
                             r_addr != r_rodada ? PROX_JOGADA :
                             r_rodada == w_ultima ? FIM_ACERTO : PROX_RODADA;
        PROX_JOGADA: begin
          r_addr   <= r_addr + 1'b1;
          r_estado <= ESPERA;
        end
        PROX_RODADA: begin
          r_rodada <= r_rodada + 1'b1;
          r_addr   <= '0;
          r_jogada <= '0;
          r_estado <= MOSTRA;
        end
        default: r_estado <= INICIAL;
      endcase
    end

  assign o_acertou     = r_estado == FIM_ACERTO;
  assign o_errou       = r_estado == FIM_ERRO;
  assign o_pronto      = o_acertou | o_errou | o_timeout;
  assign o_vez_jogador = r_estado == ESPERA;
  assign o_leds        = r_estado == MOSTRA ? r_mem[r_addr] : r_jogada;
  assign o_db_estado   = r_estado;
  assign o_db_rodada   = r_rodada;
  assign o_db_endereco = r_addr;
  assign o_db_memoria  = r_estado == INICIAL ? '0 : r_mem[r_addr];
endmodule

// File: tb/tb_jogo_sequencia_param.sv
// tb_jogo_sequencia_param: directed bench for the sequence game with a reference LFSR model.
module tb_jogo_sequencia_param;
  localparam int N = 4, P = 4, TMO = 20, TM = 3, TA = 2;

  logic       clk = 1'b0, rst = 1'b0, iniciar = 1'b0, nj = 1'b0, nt = 1'b0;
  logic [3:0] chaves = 4'h0;
  logic       acertou, errou, timeout, pronto, vez;
  logic [3:0] leds, estado, memoria;
  logic [1:0] rodada, endereco;

  jogo_sequencia_param #(
    .N_CHAVES(N), .PROFUNDIDADE(P), .TIMEOUT_CICLOS(TMO),
    .T_MOSTRA(TM), .T_APAGA(TA), .SEMENTE(16'hACE1)
  ) dut (
    .i_clock(clk), .i_reset(rst), .i_iniciar(iniciar), .i_chaves(chaves),
    .i_nivel_jogadas(nj), .i_nivel_tempo(nt),
    .o_acertou(acertou), .o_errou(errou), .o_timeout(timeout), .o_pronto(pronto),
    .o_vez_jogador(vez), .o_leds(leds), .o_db_estado(estado), .o_db_rodada(rodada),
    .o_db_endereco(endereco), .o_db_memoria(memoria)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       novo;
    logic       nj;
    int         addr;
    int         kind;
    logic [3:0] estado;
    logic [2:0] res;
  } vec_t;

  int          checks = 0, errors = 0, rnd = 0;
  logic [15:0] m_lfsr = 16'h0;
  logic [3:0]  seq [P];
  vec_t        tbl [15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    m_lfsr = !rst ? 16'hACE1 : (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0);
    #1;
  endtask

  task automatic start(input logic j, input logic t);
    iniciar = 1'b1; nj = j; nt = t;
    tick();
    chk("prepara", 32'(estado), 32'h1);
    iniciar = 1'b0;
    tick();
    chk("carrega", 32'(estado), 32'h2);
    for (int i = 0; i < P; i++) begin
      seq[i] = 4'(1) << m_lfsr[1:0];
      tick();
    end
    rnd = 0;
  endtask

  task automatic playback(input int r);
    for (int a = 0; a <= r; a++) begin
      chk("mostra", 32'({estado, leds, endereco}), 32'({4'h3, seq[a], 2'(a)}));
      repeat (TM) tick();
      chk("apaga", 32'({estado, leds}), 32'({4'h4, 4'h0}));
      repeat (TA) tick();
    end
    chk("espera", 32'({estado, vez}), 32'({4'h5, 1'b1}));
  endtask

  task automatic press(input logic [3:0] k);
    chaves = k;
    tick();
    chk("registra", 32'({estado, leds}), 32'({4'h6, k}));
    chaves = 4'h0;
    tick();
    chk("compara", 32'(estado), 32'h7);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [3:0] s, k;
    tbl[0]  = '{1'b1, 1'b1, 0, 0, 4'h9, 3'b000};
    tbl[1]  = '{1'b0, 1'b0, 0, 0, 4'h8, 3'b000};
    tbl[2]  = '{1'b0, 1'b0, 1, 0, 4'h9, 3'b000};
    tbl[3]  = '{1'b0, 1'b0, 0, 0, 4'h8, 3'b000};
    tbl[4]  = '{1'b0, 1'b0, 1, 0, 4'h8, 3'b000};
    tbl[5]  = '{1'b0, 1'b0, 2, 0, 4'h9, 3'b000};
    tbl[6]  = '{1'b0, 1'b0, 0, 0, 4'h8, 3'b000};
    tbl[7]  = '{1'b0, 1'b0, 1, 0, 4'h8, 3'b000};
    tbl[8]  = '{1'b0, 1'b0, 2, 0, 4'h8, 3'b000};
    tbl[9]  = '{1'b0, 1'b0, 3, 0, 4'hA, 3'b100};
    tbl[10] = '{1'b1, 1'b1, 0, 1, 4'hE, 3'b010};
    tbl[11] = '{1'b1, 1'b1, 0, 2, 4'hE, 3'b010};
    tbl[12] = '{1'b1, 1'b0, 0, 0, 4'h9, 3'b000};
    tbl[13] = '{1'b0, 1'b0, 0, 0, 4'h8, 3'b000};
    tbl[14] = '{1'b0, 1'b0, 1, 0, 4'hA, 3'b100};

    repeat (3) tick();
    chk("reset_outs", 32'({acertou, errou, timeout, pronto, vez, leds, estado, rodada, endereco, memoria}), 32'h0);
    rst = 1'b1;
    tick();
    chk("idle", 32'(estado), 32'h0);

    start(1'b1, 1'b1);
    chk("first_mostra", 32'({estado, leds}), 32'({4'h3, seq[0]}));
    tick();
    rst = 1'b0;
    tick();
    chk("reset_mid", 32'({acertou, errou, timeout, pronto, vez, leds, estado, rodada, endereco, memoria}), 32'h0);
    rst = 1'b1;
    tick();
    chk("idle2", 32'(estado), 32'h0);

    for (int i = 0; i < 15; i++) begin
      if (tbl[i].novo) start(tbl[i].nj, 1'b0);
      if (tbl[i].addr == 0) playback(rnd);
      s = seq[tbl[i].addr];
      k = tbl[i].kind == 0 ? s : tbl[i].kind == 1 ? {s[2:0], s[3]} : 4'b0011;
      chk("memoria", 32'(memoria), 32'(s));
      press(k);
      chk("outcome", 32'(estado), 32'(tbl[i].estado));
      chk("result", 32'({acertou, errou, timeout}), 32'(tbl[i].res));
      chk("pronto", 32'(pronto), 32'(|tbl[i].res));
      chk("rodada", 32'(rodada), 32'(rnd));
      if (tbl[i].estado == 4'h8) begin
        tick();
        chk("back_espera", 32'(estado), 32'h5);
      end
      if (tbl[i].estado == 4'h9) begin
        tick();
        rnd++;
        chk("next_round", 32'(estado), 32'h3);
      end
    end

    start(1'b1, 1'b1);
    chaves = seq[0];
    playback(0);
    iniciar = 1'b1;
    repeat (4) tick();
    iniciar = 1'b0;
    chk("held_key", 32'({estado, vez}), 32'({4'h5, 1'b1}));
    chaves = 4'h0;
    tick();
    press(seq[0]);
    chk("after_held", 32'(estado), 32'h9);
    tick();
    playback(1);
`ifdef JOGO_TIMEOUT_EN
    repeat (TMO - 1) tick();
    chk("before_timeout", 32'(estado), 32'h5);
    tick();
    chk("timeout_state", 32'(estado), 32'hD);
    chk("timeout_outs", 32'({acertou, errou, timeout, pronto}), 32'b0011);
`else
    repeat (2 * TMO) tick();
    chk("no_timeout", 32'({estado, timeout, pronto}), 32'({4'h5, 1'b0, 1'b0}));
    press({seq[0][2:0], seq[0][3]});
    chk("late_wrong", 32'({estado, errou, pronto}), 32'({4'hE, 1'b1, 1'b1}));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/jogo_sequencia_param.md
# jogo_sequencia_param

Parametrised sequence-memory game core, the successor to the fixed 4-key, 16-step game top. It generates a random one-hot sequence internally, shows the sequence on the LEDs at the start of every round, and then accepts the player's replay from the keys. The sequence grows by one step per round. Key count, sequence depth and time limits are parameters. It sits directly under the board top; the board top adds 7-segment decoding of the debug outputs.

## Interface
- N_CHAVES, 4: number of keys/LEDs, 2..8.
- PROFUNDIDADE, 16: maximum sequence length, 2..64.
- TIMEOUT_CICLOS, 5000: cycles allowed per player move.
- T_MOSTRA, 1000: cycles each step is lit during playback.
- T_APAGA, 250: dark gap between playback steps.
- SEMENTE, 16'hACE1: LFSR reset value; must be non-zero.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- iniciar  in  1  starts a game; level-sampled.
- chaves  in  N_CHAVES  player keys, already synchronised, active-high.
- nivel_jogadas  in  1  0 = play PROFUNDIDADE/2 rounds; 1 = play PROFUNDIDADE rounds. Registered at game start.
- nivel_tempo  in  1  1 = per-move timeout active. Registered at game start.
- acertou  out  1  game won.
- errou  out  1  game lost on a wrong key.
- timeout  out  1  game lost on timeout.
- pronto  out  1  game finished (any outcome).
- vez_jogador  out  1  waiting for a player move.
- leds  out  N_CHAVES  playback step or echo of the last key pressed.
- db_estado  out  4  state code.
- db_rodada  out  $clog2(PROFUNDIDADE)  current round index.
- db_endereco  out  $clog2(PROFUNDIDADE)  current compare address.
- db_memoria  out  N_CHAVES  sequence word at db_endereco.

## Operation
- **Reset (reset=0 at a clock edge):**
  - State goes to INICIAL.
  - All outputs are 0.
  - LFSR loads SEMENTE.
  - Counters and registers clear.
  - The sequence memory is not cleared.
- **LFSR:** 16-bit Galois LFSR, taps 16,14,13,11. Free-running every cycle from reset, so the game content depends on when iniciar arrives.
- **States and codes:**
  - INICIAL(0): waits for iniciar=1.
  - PREPARA(1): registers the nivel_* inputs; clears round, address and timers.
  - CARREGA(2): writes mem[addr] = onehot(lfsr % N_CHAVES). Runs for PROFUNDIDADE cycles.
  - MOSTRA(3): leds = mem[addr] for T_MOSTRA cycles.
  - APAGA(4): leds = 0 for T_APAGA cycles.
    - If addr ≠ rodada: addr+1 and return to MOSTRA.
    - Otherwise: clear addr and go to ESPERA.
  - ESPERA(5): vez_jogador=1. Waits for jogada_feita.
  - REGISTRA(6): latches chaves into jogada; leds = jogada from here until the next MOSTRA.
  - COMPARA(7): checks jogada == mem[addr].
    - Mismatch: FIM_ERRO.
    - Match with addr ≠ rodada: PROX_JOGADA.
    - Match with addr == rodada and rodada == ultima: FIM_ACERTO.
    - Otherwise: PROX_RODADA.
  - PROX_JOGADA(8): addr+1, clears the move timer, goes to ESPERA.
  - PROX_RODADA(9): rodada+1, clears addr, goes to MOSTRA.
  - FIM_ACERTO(A), FIM_ERRO(E), FIM_TIMEOUT(D): end states.
- **End states:**
  - pronto=1, plus exactly one of acertou, errou, timeout.
  - Outputs are held until iniciar=1, which goes to PREPARA (new sequence).
- **Last round:** ultima = PROFUNDIDADE-1 if nivel_jogadas_reg, else PROFUNDIDADE/2-1.
- **Move detection:** jogada_feita = (chaves ≠ 0) and (chaves_prev == 0), with chaves_prev registered every cycle.
  - A multi-hot press can never match the one-hot stored word, so it is a wrong move.
  - Keys already held when ESPERA is entered do not count until they are released.
- **Move timer:** counts only in ESPERA, and only when nivel_tempo_reg=1. When it reaches TIMEOUT_CICLOS-1, go to FIM_TIMEOUT.
- **Timeout and press in the same cycle:** the press wins.
- **iniciar outside INICIAL and the end states:** ignored.

## Timing
- The FSM is a Moore machine; all outputs are registered or decoded from state. No combinational input-to-output path.
- From iniciar sampled high to the first MOSTRA cycle: 1 + PROFUNDIDADE cycles.
- Press latency:
  - Edge in cycle t → REGISTRA at t+1 → COMPARA at t+2.
  - The outcome state is reached at t+3.
- Round r playback lasts (r+1)·(T_MOSTRA+T_APAGA) cycles.
- reset=0 in any state returns to INICIAL on the next edge.

## Configuration
- JOGO_TIMEOUT_EN defined: the move timer, FIM_TIMEOUT and the nivel_tempo register are present.
- JOGO_TIMEOUT_EN undefined:
  - No timer logic is built.
  - nivel_tempo is ignored and timeout is tied to 0.
  - ESPERA waits indefinitely.

## Structure
- Package jogo_pkg holds:
  - the state enum with the codes above;
  - the LFSR tap constant;
  - the onehot function.
- Sub-module jogo_lfsr: the 16-bit LFSR with SEMENTE parameter and a synchronous active-low reset.
- FSM, counters and memory stay in the top.

## Test plan
- **Win, N_CHAVES=4, PROFUNDIDADE=4, nivel_jogadas=1:** mirror leds during MOSTRA and replay them → acertou=1, pronto=1 after round 3; db_estado=A.
- **Wrong key:** in round 0, press a key other than db_memoria → errou=1, pronto=1 three cycles after the edge; db_estado=E.
- **Timeout:** nivel_tempo=1, TIMEOUT_CICLOS=20, no press → timeout=1 exactly 20 cycles after entering ESPERA. With JOGO_TIMEOUT_EN undefined, the same stimulus leaves the FSM in state 5 indefinitely.
- **Multi-key and held key:**
  - chaves=4'b0011 press → errou.
  - A key held from playback into ESPERA with no new edge → no move registered.
- **Easy level:** nivel_jogadas=0, PROFUNDIDADE=8 → acertou after round 3, where db_rodada=3.
- **Reset and restart:**
  - reset=0 mid-MOSTRA → next cycle all outputs 0 and db_estado=0.
  - iniciar from FIM_ERRO → PREPARA, then a new sequence loaded.
